// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the two-channel TDM demultiplexer.
//   state_e   : lock state machine encoding (HUNT, EXPECT_B, EXPECT_A)
//   DEF_WIDTH : default sample width
//   DEF_ERR_W : default sync-error counter width
package tdm_demux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ERR_W = 8;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    EXPECT_B = 2'd1,
    EXPECT_A = 2'd2
  } state_e;

endpackage

// File: rtl/tdm_demux2_sat_counter.sv
// Saturating up-counter used as the sync-error counter of tdm_demux2.
// Only compiled when TDM_DEMUX_ERRCNT_EN is defined, matching the single
// place it is instantiated.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   inc   : add one this cycle (ignored once saturated)
//   count : current count, sticks at all-ones
`ifdef TDM_DEMUX_ERRCNT_EN
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer with frame-sync lock state machine.
// Splits an interleaved A,B,A,B stream into held per-channel outputs with
// one-cycle update strobes; in_sync marks channel A samples.
// Optional feature macro: TDM_DEMUX_ERRCNT_EN adds the saturating err_cnt
// output (ERR_W bits) counting sync_err pulses.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/valid/sync  : incoming sample stream (no backpressure)
//   out_a, out_a_valid  : last channel A sample and its update pulse
//   out_b, out_b_valid  : last channel B sample and its update pulse
//   pair_valid          : out_a/out_b now hold one frame's A/B pair
//   locked              : aligned to the frame (not hunting)
//   sync_err            : framing violation pulse
//   err_cnt             : saturating sync_err count (macro only)
//
// state    | meaning
// HUNT     | not aligned; waiting for a sample with in_sync
// EXPECT_B | A captured; next valid sample should be B
// EXPECT_A | pair complete; next valid sample should be A
module tdm_demux2
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef TDM_DEMUX_ERRCNT_EN
  , parameter int ERR_W = DEF_ERR_W
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out_a,
  output logic             out_a_valid,
  output logic [WIDTH-1:0] out_b,
  output logic             out_b_valid,
  output logic             pair_valid,
  output logic             locked,
  output logic             sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  , output logic [ERR_W-1:0] err_cnt
`endif
);

  state_e           state_q, state_d;
  logic             cap_a_d, cap_b_d, err_d;
  logic [WIDTH-1:0] out_a_q, out_b_q;
  logic             a_valid_q, b_valid_q, pair_q, err_q;

  always_comb begin
    state_d = state_q;
    cap_a_d = 1'b0;
    cap_b_d = 1'b0;
    err_d   = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          // Unsynced samples are silently dropped while hunting.
          if (in_sync) begin
            cap_a_d = 1'b1;
            state_d = EXPECT_B;
          end
        end
        EXPECT_B: begin
          // A second sync restarts the frame on this sample; lock is kept.
          cap_a_d = in_sync;
          cap_b_d = !in_sync;
          err_d   = in_sync;
          state_d = in_sync ? EXPECT_B : EXPECT_A;
        end
        EXPECT_A: begin
          if (in_sync) begin
            cap_a_d = 1'b1;
            state_d = EXPECT_B;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      out_a_q   <= '0;
      out_b_q   <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      pair_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (cap_a_d) out_a_q <= in_data;
      if (cap_b_d) out_b_q <= in_data;
      a_valid_q <= cap_a_d;
      b_valid_q <= cap_b_d;
      // B is only ever captured after an A of the same frame.
      pair_q    <= cap_b_d;
      err_q     <= err_d;
    end
  end

  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_a_valid = a_valid_q;
  assign out_b_valid = b_valid_q;
  assign pair_valid  = pair_q;
  assign sync_err    = err_q;
  assign locked      = (state_q != HUNT);

`ifdef TDM_DEMUX_ERRCNT_EN
  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_d),
    .count (err_cnt)
  );
`endif

endmodule
